// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  localparam int DMEM_WORD_BYTES = 4;
  localparam int DMEM_IDX_LSB    = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } dmem_req_t;

endpackage

// File: rtl/dmem_sram_array.sv
// DEPTH_WORDS x 32 storage built as one byte-wide array per lane.
// Each lane has its own write enable and a registered read port; reset clears every word.
module dmem_sram_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  localparam int IDX_W = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  input  logic [3:0]       wstrb,
  output logic [31:0]      rdata
);

  genvar gi;
  generate
    for (gi = 0; gi < DMEM_WORD_BYTES; gi++) begin : g_lane
      logic [7:0] mem_q [DEPTH_WORDS];
      logic [7:0] rd_q;

      // Lane storage: clear on reset, masked write or registered read on an enabled access.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int w = 0; w < DEPTH_WORDS; w++) begin
            mem_q[w] <= '0;
          end
          rd_q <= '0;
        end else if (en) begin
          if (we) begin
            if (wstrb[gi]) begin
              mem_q[idx] <= wdata[8*gi +: 8];
            end
          end else begin
            rd_q <= mem_q[idx];
          end
        end
      end

      assign rdata[8*gi +: 8] = rd_q;
    end
  endgenerate

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, fixed wait-state latency, then a response
// handshake. Optional alignment checking is enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_INIT = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
  localparam logic ZERO_WAIT = (WAIT_CYCLES == 0);

  dmem_state_t state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  dmem_req_t   req_q, req_d;
  logic        err_q, err_d;
  logic        load_q, load_d;

  dmem_req_t        req_in;
  dmem_req_t        acc_req;
  logic             acc_fire;
  logic             out_of_range;
  logic             misalign;
  logic             acc_bad;
  logic [IDX_W-1:0] arr_idx;
  logic [31:0]      arr_rdata;

  assign req_in = '{write: req_write, addr: req_addr, wdata: req_wdata, wstrb: req_wstrb};

  // Access decode: with zero wait states the access uses the live request on the accept edge,
  // otherwise it uses the latched request on the last wait cycle.
  always_comb begin
    acc_req      = (state_q == IDLE) ? req_in : req_q;
    acc_fire     = ((state_q == IDLE) && req_valid && ZERO_WAIT) ||
                   ((state_q == WAIT) && (cnt_q == 4'd0));
    out_of_range = |acc_req.addr[31:DMEM_IDX_LSB+IDX_W];
    arr_idx      = acc_req.addr[DMEM_IDX_LSB+IDX_W-1:DMEM_IDX_LSB];
  end

`ifdef DMEM_ALIGN_CHECK_EN
  assign misalign = |acc_req.addr[DMEM_IDX_LSB-1:0];
`else
  // Byte offset is ignored; the access goes to the enclosing word.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^acc_req.addr[DMEM_IDX_LSB-1:0];
  assign misalign = 1'b0;
`endif

  assign acc_bad = out_of_range | misalign;

  dmem_sram_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .en    (acc_fire && !acc_bad),
    .we    (acc_req.write),
    .idx   (arr_idx),
    .wdata (acc_req.wdata),
    .wstrb (acc_req.wstrb),
    .rdata (arr_rdata)
  );

  // Next-state logic: request latch, wait countdown and response status flags.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    err_d   = err_q;
    load_d  = load_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          req_d = req_in;
          if (ZERO_WAIT) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
          err_d   = 1'b0;
          load_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    // Status is captured on the same edge as the array access so it lines up with read data.
    if (acc_fire) begin
      err_d  = acc_bad;
      load_d = !acc_bad && !acc_req.write;
    end
  end

  // State registers with synchronous reset; a reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      err_q   <= 1'b0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      err_q   <= err_d;
      load_q  <= load_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_err   = err_q;
  assign rsp_rdata = load_q ? arr_rdata : 32'd0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench: dut (WAIT_CYCLES=2) and dut0 (WAIT_CYCLES=0), 256 words each.
module tb_dmem_responder;

`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid [2];
  logic        req_write [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_wstrb [2];
  logic        rsp_ready [2];
  logic        req_ready [2];
  logic        rsp_valid [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_wstrb(req_wstrb[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0])
  );

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_wstrb(req_wstrb[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1])
  );

  task automatic chk(input string tag, input string what, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, what, obs, exp);
    end
  endtask

  // One transaction on DUT d, started just after a negedge; hold = cycles rsp_ready stays low in RESP.
  task automatic txn(input int d, input string tag, input logic w, input logic [31:0] a,
                     input logic [31:0] wd, input logic [3:0] ws, input int hold,
                     input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
    int lat;
    logic [31:0] rd0;
    logic        e0;
    chk(tag, "idle_ready", 32'(req_ready[d]), 32'd1);
    req_valid[d] = 1'b1; req_write[d] = w; req_addr[d] = a;
    req_wdata[d] = wd;   req_wstrb[d] = ws;
    @(negedge clk);
    // Scramble inputs after acceptance: the latched request must not follow them.
    req_valid[d] = 1'b0; req_write[d] = ~w; req_addr[d] = 32'hFFFF_FFFF;
    req_wdata[d] = ~wd;  req_wstrb[d] = ~ws;
    lat = 1;
    while (!rsp_valid[d] && lat < 20) begin
      chk(tag, "wait_ready", 32'(req_ready[d]), 32'd0);
      @(negedge clk);
      lat++;
    end
    chk(tag, "latency", 32'(lat), 32'(exp_lat));
    chk(tag, "resp_ready", 32'(req_ready[d]), 32'd0);
    chk(tag, "rdata", rsp_rdata[d], exp_rd);
    chk(tag, "err", 32'(rsp_err[d]), 32'(exp_err));
    rd0 = rsp_rdata[d];
    e0  = rsp_err[d];
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk(tag, "hold_valid", 32'(rsp_valid[d]), 32'd1);
      chk(tag, "hold_rdata", rsp_rdata[d], rd0);
      chk(tag, "hold_err", 32'(rsp_err[d]), 32'(e0));
      chk(tag, "hold_ready", 32'(req_ready[d]), 32'd0);
    end
    rsp_ready[d] = 1'b1;
    @(negedge clk);
    rsp_ready[d] = 1'b0;
    chk(tag, "back_idle", 32'(req_ready[d]), 32'd1);
    chk(tag, "valid_drop", 32'(rsp_valid[d]), 32'd0);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_write[d] = 1'b0; req_addr[d] = '0;
      req_wdata[d] = '0;   req_wstrb[d] = '0;   rsp_ready[d] = 1'b0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state on both instances
    for (int d = 0; d < 2; d++) begin
      chk("reset", "req_ready", 32'(req_ready[d]), 32'd1);
      chk("reset", "rsp_valid", 32'(rsp_valid[d]), 32'd0);
      chk("reset", "rsp_rdata", rsp_rdata[d], 32'd0);
      chk("reset", "rsp_err", 32'(rsp_err[d]), 32'd0);
    end
    txn(0, "ld_cleared", 1'b0, 32'h44, 32'h0, 4'hF, 0, 32'h0, 1'b0, 3);

    // 1: store then load, 3-cycle latency each
    txn(0, "t1_st", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 32'h0, 1'b0, 3);
    txn(0, "t1_ld", 1'b0, 32'h10, 32'h0, 4'h0, 0, 32'hDEADBEEF, 1'b0, 3);

    // 2: partial store by byte strobes; response held 5 cycles (also covers item 4)
    txn(0, "t2_st", 1'b1, 32'h20, 32'h11223344, 4'hF, 0, 32'h0, 1'b0, 3);
    txn(0, "t2_stp", 1'b1, 32'h20, 32'hAABBCCDD, 4'h5, 0, 32'h0, 1'b0, 3);
    txn(0, "t2_ld_hold", 1'b0, 32'h20, 32'h0, 4'h0, 5, 32'h11BB33DD, 1'b0, 3);
    txn(0, "t2_st_nostrb", 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 0, 32'h0, 1'b0, 3);
    txn(0, "t2_ld2", 1'b0, 32'h20, 32'h0, 4'h0, 0, 32'h11BB33DD, 1'b0, 3);

    // 3: out-of-range access, no wrap into word 0
    txn(0, "t3_st0", 1'b1, 32'h0, 32'h0BADF00D, 4'hF, 0, 32'h0, 1'b0, 3);
    txn(0, "t3_ld_oor", 1'b0, 32'h400, 32'h0, 4'h0, 0, 32'h0, 1'b1, 3);
    txn(0, "t3_st_oor", 1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 0, 32'h0, 1'b1, 3);
    txn(0, "t3_ld0", 1'b0, 32'h0, 32'h0, 4'h0, 0, 32'h0BADF00D, 1'b0, 3);
    txn(0, "t3_ld_top", 1'b0, 32'h3FC, 32'h0, 4'h0, 0, 32'h0, 1'b0, 3);

    // 6: misaligned load, on both latencies
    txn(0, "t6_ld12", 1'b0, 32'h12, 32'h0, 4'h0, 0, ALIGN ? 32'h0 : 32'hDEADBEEF, ALIGN, 3);
    txn(1, "t6_w0_st", 1'b1, 32'h10, 32'hCAFEF00D, 4'hF, 0, 32'h0, 1'b0, 1);
    txn(1, "t6_w0_ld12", 1'b0, 32'h12, 32'h0, 4'h0, 0, ALIGN ? 32'h0 : 32'hCAFEF00D, ALIGN, 1);
    txn(1, "t6_w0_ld_oor", 1'b0, 32'h800, 32'h0, 4'h0, 2, 32'h0, 1'b1, 1);
    txn(1, "t6_w0_ld10", 1'b0, 32'h10, 32'h0, 4'h0, 0, 32'hCAFEF00D, 1'b0, 1);

    // 5: reset during WAIT discards the store and produces no response
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 32'h8;
    req_wdata[0] = 32'h5; req_wstrb[0] = 4'hF;
    @(negedge clk);
    req_valid[0] = 1'b0;
    chk("t5", "in_wait_ready", 32'(req_ready[0]), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t5", "no_stray_rsp", 32'(rsp_valid[0]), 32'd0);
      chk("t5", "ready_after_rst", 32'(req_ready[0]), 32'd1);
      @(negedge clk);
    end
    txn(0, "t5_ld8", 1'b0, 32'h8, 32'h0, 4'h0, 0, 32'h0, 1'b0, 3);
    txn(0, "t5_ld10", 1'b0, 32'h10, 32'h0, 4'h0, 0, 32'h0, 1'b0, 3);
    txn(1, "t5_w0_ld10", 1'b0, 32'h10, 32'h0, 4'h0, 0, 32'h0, 1'b0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
